// File: rtl/addsub_pipe_cla.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// The operand is split into CHUNK-bit slices; each pipeline stage resolves one slice with a
// CHUNK-bit lookahead block and hands its registered carry to the next stage.
// Optional signed saturation on the final stage: define ADDSUB_SAT_EN.
module addsub_pipe_cla #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovfl,
  output logic             zero,
  output logic             sat
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("addsub_pipe_cla: WIDTH must be a multiple of CHUNK");
  end

  // Carry vector c[0..CHUNK] of one slice; every carry is a flattened generate/propagate
  // sum-of-products, so no carry depends on the previous bit's carry.
  function automatic logic [CHUNK:0] cla_carries(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;
    logic             term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 1; i <= CHUNK; i++) begin
      term = ci;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             c0;

  // Single global stall: everything advances unless a finished result is waiting.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign bx       = sub ? ~b : b;
  assign c0       = sub | cin;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;

  // Valid bits shift along with the data; bubbles travel as zeros.
  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = in_valid;
  end

  // Intermediate stages: each keeps only the upper slices still to be added and the lower
  // sum slices already finished, so register widths shrink/grow stage by stage.
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
    localparam int unsigned Done = (k + 1) * CHUNK;
    localparam int unsigned Left = WIDTH - Done;

    logic [CHUNK-1:0] sa;
    logic [CHUNK-1:0] sb;
    logic [CHUNK-1:0] ss;
    logic             ci;
    logic [CHUNK:0]   car;
    logic [Left-1:0]  na;
    logic [Left-1:0]  nb;
    logic [Done-1:0]  nlo;
    logic [Left-1:0]  a_q;
    logic [Left-1:0]  b_q;
    logic [Done-1:0]  lo_q;
    logic             c_q;

    if (k == 0) begin : g_first
      assign sa  = a[CHUNK-1:0];
      assign sb  = bx[CHUNK-1:0];
      assign ci  = c0;
      assign na  = a[WIDTH-1:CHUNK];
      assign nb  = bx[WIDTH-1:CHUNK];
      assign nlo = ss;
    end else begin : g_next
      assign sa  = g_stage[k-1].a_q[CHUNK-1:0];
      assign sb  = g_stage[k-1].b_q[CHUNK-1:0];
      assign ci  = g_stage[k-1].c_q;
      assign na  = g_stage[k-1].a_q[Left+CHUNK-1:CHUNK];
      assign nb  = g_stage[k-1].b_q[Left+CHUNK-1:CHUNK];
      assign nlo = {ss, g_stage[k-1].lo_q};
    end

    assign car = cla_carries(sa, sb, ci);
    assign ss  = sa ^ sb ^ car[CHUNK-1:0];

    // Stage data only moves on advance; no reset needed since valid bits qualify it.
    always_ff @(posedge clk) begin
      if (adv) begin
        a_q  <= na;
        b_q  <= nb;
        lo_q <= nlo;
        c_q  <= car[CHUNK];
      end
    end
  end

  logic [CHUNK-1:0] fa;
  logic [CHUNK-1:0] fb;
  logic [CHUNK-1:0] fs;
  logic             fc;
  logic [CHUNK:0]   fcar;
  logic [WIDTH-1:0] raw_sum;

  if (STAGES == 1) begin : g_single
    assign fa      = a;
    assign fb      = bx;
    assign fc      = c0;
    assign raw_sum = fs;
  end else begin : g_multi
    assign fa      = g_stage[STAGES-2].a_q;
    assign fb      = g_stage[STAGES-2].b_q;
    assign fc      = g_stage[STAGES-2].c_q;
    assign raw_sum = {fs, g_stage[STAGES-2].lo_q};
  end

  assign fcar = cla_carries(fa, fb, fc);
  assign fs   = fa ^ fb ^ fcar[CHUNK-1:0];

  logic [WIDTH-1:0] s_d;
  logic             cout_d;
  logic             ovfl_d;
  logic             zero_d;
  logic             sat_d;

  // Final-stage flags; optional clamp applies to s only, cout/ovfl stay raw.
  always_comb begin
    s_d    = raw_sum;
    cout_d = fcar[CHUNK];
    ovfl_d = fcar[CHUNK] ^ fcar[CHUNK-1];
    sat_d  = 1'b0;
`ifdef ADDSUB_SAT_EN
    if (ovfl_d) begin
      // Wrapped sign is the opposite of the true sign, so clamp toward the true side.
      s_d   = raw_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      sat_d = 1'b1;
    end
`endif
    zero_d = (s_d == '0);
  end

  // Valid pipeline and output registers; outputs load only when a real result arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovfl  <= 1'b0;
      zero  <= 1'b0;
      sat   <= 1'b0;
    end else if (adv) begin
      vld_q <= vld_d;
      if (vld_d[STAGES-1]) begin
        s    <= s_d;
        cout <= cout_d;
        ovfl <= ovfl_d;
        zero <= zero_d;
        sat  <= sat_d;
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];

endmodule

// File: tb/tb_addsub_pipe_cla.sv
// Self-checking bench for addsub_pipe_cla (WIDTH=16, CHUNK=4 plus a CHUNK=16 instance).
module tb_addsub_pipe_cla;

  localparam int N_STREAM = 24;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovfl;
    logic        zero;
    logic        sat;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovfl;
    logic        zero;
    logic        sat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic [15:0] a, b, s;
  logic        cout, ovfl, zero, sat;

  logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1;
  logic [15:0] a1, b1, s1;
  logic        cout1, ovfl1, zero1, sat1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addsub_pipe_cla #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .s(s),
    .cout(cout), .ovfl(ovfl), .zero(zero), .sat(sat)
  );

  addsub_pipe_cla #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1), .s(s1),
    .cout(cout1), .ovfl(ovfl1), .zero(zero1), .sat(sat1)
  );

  // Reference: plain integer arithmetic on the signed/unsigned interpretations.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb);
    logic [16:0] full;
    int          ix, iy, r;
    res_t        o;
    ix     = $signed(x);
    iy     = $signed(y);
    full   = {1'b0, x} + {1'b0, (sb ? ~y : y)} + {16'd0, (sb | ci)};
    r      = sb ? (ix - iy) : (ix + iy + (ci ? 1 : 0));
    o.s    = full[15:0];
    o.cout = full[16];
    o.ovfl = (r > 32767) || (r < -32768);
    o.sat  = 1'b0;
`ifdef ADDSUB_SAT_EN
    if (o.ovfl) begin
      o.s   = (r > 0) ? 16'h7FFF : 16'h8000;
      o.sat = 1'b1;
    end
`endif
    o.zero = (o.s == 16'h0000);
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  vec_t vt[6];
  res_t q[$];
  res_t e;

  initial begin
    int lat, sent, got, seen;
    logic stalled;
    logic [19:0] held;

    vt[0] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef ADDSUB_SAT_EN
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    vt[4] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_outputs", {12'd0, s, cout, ovfl, zero, sat}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid_c16", {31'd0, out_valid1}, 32'd0);

    // Directed vectors, one at a time, checking latency and every flag.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = vt[i].a; b = vt[i].b; cin = vt[i].cin; sub = vt[i].sub;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_result", i), {12'd0, s, cout, ovfl, zero, sat},
          {12'd0, vt[i].s, vt[i].cout, vt[i].ovfl, vt[i].zero, vt[i].sat});
    end

    // Random back-to-back stream with out_ready toggling 1010..
    @(negedge clk);
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 600 && got < N_STREAM; cyc++) begin
      if (stalled)
        chk("stall_hold", {11'd0, out_valid, s, cout, ovfl, zero, sat}, {11'd0, 1'b1, held});
      out_ready = (cyc % 2 == 0);
      in_valid  = (sent < N_STREAM);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      if (cyc % 5 == 0) a = 16'h7FFF;
      if (cyc % 7 == 0) a = 16'h8000;
      #1;
      chk("in_ready_eq_adv", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream_dup", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("stream_%0d", got), {12'd0, s, cout, ovfl, zero, sat},
              {12'd0, e.s, e.cout, e.ovfl, e.zero, e.sat});
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        sent++;
      end
      stalled = out_valid && !out_ready;
      held    = {s, cout, ovfl, zero, sat};
      @(negedge clk);
    end
    chk("stream_count", got, N_STREAM);
    chk("stream_leftover", q.size(), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Three ops in flight, then a one-cycle reset: nothing may emerge.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'b0; sub = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("rst_flush_no_out", seen, 0);
    chk("rst_flush_s", {16'd0, s}, 32'd0);

    // Single-stage build: result one edge after acceptance, one per cycle.
    for (int i = 0; i < 5; i++) begin
      in_valid1 = 1'b1;
      a1   = (i == 0) ? 16'h7FFF : 16'($urandom);
      b1   = (i == 0) ? 16'h0001 : 16'($urandom);
      cin1 = 1'($urandom_range(0, 1));
      sub1 = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      e = model(a1, b1, cin1, sub1);
      @(posedge clk);
      #1;
      chk($sformatf("c16_valid_%0d", i), {31'd0, out_valid1}, 32'd1);
      chk($sformatf("c16_result_%0d", i), {12'd0, s1, cout1, ovfl1, zero1, sat1},
          {12'd0, e.s, e.cout, e.ovfl, e.zero, e.sat});
    end
    in_valid1 = 1'b0;
    @(posedge clk);
    #1;
    chk("c16_drained", {31'd0, out_valid1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
